// File: rtl/tff_count_ctrl_if.sv
// tff_count_ctrl_if: board-key, counter-feedback and counter-control signals of the sequencing controller
interface tff_count_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             key_start;
    logic             key_stop;
    logic             key_clear;
    logic             reload;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_en;
    logic             cnt_clr;
    logic             tick;
    logic             done;
    logic [1:0]       state;

    modport master (
        output key_start, key_stop, key_clear, reload, limit, cnt_q,
        input  cnt_en, cnt_clr, tick, done, state
    );

    modport slave (
        input  key_start, key_stop, key_clear, reload, limit, cnt_q,
        output cnt_en, cnt_clr, tick, done, state
    );
endinterface

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: run/pause/done sequencer, count-tick prescaler and terminal-count detect for a T-flip-flop counter chain
module tff_count_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 50000000,
    parameter int PW    = 26
) (
    input logic            clk,
    input logic            clr,
    tff_count_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_pre;
    logic [PW-1:0]    w_pre_next;
    logic             r_prev_start;
    logic             r_prev_stop;
    logic             r_prev_clear;
    logic             w_start;
    logic             w_stop;
    logic             w_clear;
    logic             w_tick;
    logic             w_at_limit;
    logic             w_en;
    logic             w_clr;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_lim;

    assign w_q        = bus.cnt_q;
    assign w_lim      = bus.limit;
    assign w_at_limit = (w_q == w_lim);
    assign w_start    = bus.key_start & ~r_prev_start;
    assign w_stop     = bus.key_stop  & ~r_prev_stop;
    assign w_clear    = bus.key_clear & ~r_prev_clear;
    assign w_tick     = ~clr & (r_state == RUN) & (r_pre == PW'(DIV - 1));

    // Next state and counter control; clear outranks stop, stop outranks start
    always_comb begin
        w_next = r_state;
        w_en   = 1'b0;
        w_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_clear) w_clr = 1'b1;
                else if (w_start) w_next = RUN;
            end
            RUN: begin
                if (w_clear) begin
                    w_clr  = 1'b1;
                    w_next = IDLE;
                end else if (w_stop) begin
                    w_next = PAUSE;
                end else if (w_tick) begin
                    if (!w_at_limit) w_en = 1'b1;
                    else if (bus.reload) w_clr = 1'b1;
                    else w_next = DONE;
                end
            end
            PAUSE: begin
                if (w_clear) begin
                    w_clr  = 1'b1;
                    w_next = IDLE;
                end else if (w_start) begin
                    w_next = RUN;
                end
            end
            default: begin
                if (w_clear) begin
                    w_clr  = 1'b1;
                    w_next = IDLE;
                end else if (w_start) begin
                    w_clr  = 1'b1;
                    w_next = RUN;
                end
            end
        endcase
    end

    // Prescaler advances in RUN, freezes in PAUSE, and sits at zero otherwise so every fresh run starts a full period
    always_comb begin
        w_pre_next = (r_state == RUN)   ? ((r_pre == PW'(DIV - 1)) ? '0 : r_pre + PW'(1)) :
                     (r_state == PAUSE) ? r_pre : '0;
    end

    // State, prescaler and key history; history loads 1 in reset so held keys do not fire on release
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= IDLE;
            r_pre        <= '0;
            r_prev_start <= 1'b1;
            r_prev_stop  <= 1'b1;
            r_prev_clear <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_pre        <= w_pre_next;
            r_prev_start <= bus.key_start;
            r_prev_stop  <= bus.key_stop;
            r_prev_clear <= bus.key_clear;
        end
    end

    assign bus.cnt_clr = clr | w_clr;
    assign bus.cnt_en  = ~clr & ~w_clr & w_en;
    assign bus.tick    = w_tick;
    assign bus.done    = ~clr & (r_state == DONE);
    assign bus.state   = r_state;
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: random key/limit/reset stimulus on a DIV=4 and a DIV=1 controller, checked against a rule-level model
module tb_tff_count_ctrl;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;
    localparam int NCYC = 6000;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic ks = 1'b1, kp = 1'b0, kc = 1'b0, rl = 1'b0;
    logic [7:0] lim = 8'd5;
    logic [7:0] cq [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tff_count_ctrl_if #(.WIDTH(8)) b0 ();
    tff_count_ctrl_if #(.WIDTH(8)) b1 ();

    assign b0.key_start = ks;
    assign b0.key_stop  = kp;
    assign b0.key_clear = kc;
    assign b0.reload    = rl;
    assign b0.limit     = lim;
    assign b0.cnt_q     = cq[0];
    assign b1.key_start = ks;
    assign b1.key_stop  = kp;
    assign b1.key_clear = kc;
    assign b1.reload    = rl;
    assign b1.limit     = lim;
    assign b1.cnt_q     = cq[1];

    tff_count_ctrl #(.WIDTH(8), .DIV(4), .PW(26)) u0 (.clk(clk), .clr(clr), .bus(b0.slave));
    tff_count_ctrl #(.WIDTH(8), .DIV(1), .PW(26)) u1 (.clk(clk), .clr(clr), .bus(b1.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    int m_st [2], m_run [2], m_cnt [2];
    logic m_ps [2], m_pp [2], m_pc [2];
    int div [2];
    logic [1:0] o_st [2];
    logic o_en [2], o_cl [2], o_tk [2], o_dn [2];
    int clr_left;

    initial begin
        div = '{4, 1};
        for (int i = 0; i < 2; i++) begin
            m_st[i] = IDLE; m_run[i] = 0; m_cnt[i] = 0;
            m_ps[i] = 1'b1; m_pp[i] = 1'b1; m_pc[i] = 1'b1;
            cq[i] = 8'd0;
        end
        clr_left = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) cq[i] = m_cnt[i][7:0];
            if (cyc < 3) begin
                clr = 1'b1; ks = 1'b1;
            end else if (cyc < 8) begin
                clr = 1'b0; ks = 1'b1;
            end else begin
                if (clr_left > 0) begin
                    clr = 1'b1; clr_left--;
                end else begin
                    clr = 1'b0;
                    if ($urandom % 400 == 0) clr_left = 1 + int'($urandom % 3);
                end
                if ($urandom % 6 == 0) ks = ~ks;
                if ($urandom % 40 == 0) kp = ~kp;
                if ($urandom % 120 == 0) kc = ~kc;
                if ($urandom % 150 == 0) rl = ~rl;
                if ($urandom % 200 == 0) lim = 8'($urandom % 10);
            end
            #1;
            o_st[0] = b0.state; o_en[0] = b0.cnt_en; o_cl[0] = b0.cnt_clr; o_tk[0] = b0.tick; o_dn[0] = b0.done;
            o_st[1] = b1.state; o_en[1] = b1.cnt_en; o_cl[1] = b1.cnt_clr; o_tk[1] = b1.tick; o_dn[1] = b1.done;
            for (int i = 0; i < 2; i++) begin
                logic es, ep, ec, tk, e_en, e_cl, e_dn;
                int n_st, n_run;
                es = ks & ~m_ps[i];
                ep = kp & ~m_pp[i];
                ec = kc & ~m_pc[i];
                tk = 1'b0; e_en = 1'b0; e_cl = 1'b0; e_dn = 1'b0;
                n_st = m_st[i];
                n_run = 0;
                if (clr) begin
                    e_cl = 1'b1;
                    n_st = IDLE;
                end else begin
                    tk = (m_st[i] == RUN) && (m_run[i] % div[i] == div[i] - 1);
                    e_dn = (m_st[i] == DONE);
                    if (ec) begin
                        e_cl = 1'b1;
                        n_st = IDLE;
                    end else if (ep && m_st[i] == RUN) begin
                        n_st = PAUSE;
                    end else if (es && m_st[i] != RUN) begin
                        n_st = RUN;
                        e_cl = (m_st[i] == DONE);
                    end else if (tk) begin
                        if (m_cnt[i] != int'(lim)) e_en = 1'b1;
                        else if (rl) e_cl = 1'b1;
                        else n_st = DONE;
                    end
                    n_run = (m_st[i] == RUN) ? m_run[i] + 1 : (m_st[i] == PAUSE) ? m_run[i] : 0;
                end
                check($sformatf("state%0d", i), o_st[i], n_st == n_st ? m_st[i] : 0);
                check($sformatf("cnt_en%0d", i), o_en[i], e_en);
                check($sformatf("cnt_clr%0d", i), o_cl[i], e_cl);
                check($sformatf("tick%0d", i), o_tk[i], tk);
                check($sformatf("done%0d", i), o_dn[i], e_dn);
                m_st[i] = n_st;
                m_run[i] = n_run;
                m_ps[i] = clr ? 1'b1 : ks;
                m_pp[i] = clr ? 1'b1 : kp;
                m_pc[i] = clr ? 1'b1 : kc;
                m_cnt[i] = e_cl ? 0 : e_en ? (m_cnt[i] + 1) % 256 : m_cnt[i];
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tff_count_ctrl.md
Name: tff_count_ctrl

Overview:
- Sequencing controller for the enable/clear-driven T-flip-flop counter chain (count enable into the first stage, common clear to all stages).
- Turns start/stop/clear key requests into a run/pause/done state machine and divides clk down to a count tick.
- Gates the counter's enable per tick and detects a programmable terminal count from the switches.
- Sits between the board inputs (SW/KEY) and the counter; the counter's Q bus is fed back to it.

Parameters:
- WIDTH, 8: width of the counter being controlled, and of limit/cnt_q.
- DIV, 50000000: clk cycles per count tick. Legal range 1..2^PW-1.
- PW, 26: prescaler register width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-high reset.
- key_start  input  1  start/resume request; active-high level, already synchronized.
- key_stop  input  1  pause request; active-high level.
- key_clear  input  1  clear request; active-high level.
- reload  input  1  1 = wrap to 0 at limit; 0 = stop in DONE at limit.
- limit  input  WIDTH  terminal count.
- cnt_q  input  WIDTH  current counter value, fed back from the counter.
- cnt_en  output  1  counter enable; the counter increments on the edge where this is 1.
- cnt_clr  output  1  counter synchronous clear.
- tick  output  1  prescaler tick; 1 cycle wide.
- done  output  1  high while in DONE.
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
Edge detection
- Each key has a previous-value register; the request is key & ~prev.
- During clr, prev regs load 1, so a key held through reset does not fire.
- Priority when several edges occur in the same cycle: clear > stop > start.

Reset (clr=1)
- state=IDLE, prescaler=0.
- Outputs: cnt_clr=1, cnt_en=0, tick=0, done=0.
- Takes effect on the next edge from any state, including mid-RUN.

Prescaler
- Increments only in RUN.
- At DIV-1: tick=1 that cycle (combinational from state==RUN and pre==DIV-1), and pre wraps to 0.
- Held in PAUSE.
- Forced to 0 in IDLE and DONE, and on every entry to RUN from IDLE or DONE.
- DIV=1: tick every RUN cycle.

State transitions
- IDLE:
  - clear: cnt_clr=1 for 1 cycle, stay in IDLE.
  - start: go to RUN.
  - stop: ignored.
- RUN:
  - clear: cnt_clr=1, go to IDLE.
  - stop: go to PAUSE. A tick in the same cycle is suppressed (cnt_en=0).
  - On tick with cnt_q != limit: cnt_en=1.
  - On tick with cnt_q == limit and reload=1: cnt_clr=1 (counter returns to 0), stay in RUN.
  - On tick with cnt_q == limit and reload=0: go to DONE, cnt_en=0.
- PAUSE:
  - start: go to RUN, prescaler resumes from its held value.
  - clear: cnt_clr=1, go to IDLE.
- DONE:
  - done=1; counter is held (cnt_en=0).
  - start: cnt_clr=1, go to RUN (restart from 0).
  - clear: cnt_clr=1, go to IDLE.
  - stop: ignored.

Output rules
- cnt_en and cnt_clr are combinational from state, tick, edges and the compare.
- They are never both 1; cnt_clr wins.
- Latency: the counter value changes on the same edge as the tick; the compare uses the updated cnt_q at the next tick.
- limit=0: first tick goes straight to DONE (reload=0) or clears every tick (reload=1).
- If limit changes mid-run, the new value is used at the next tick.
- If cnt_q > limit (limit lowered below the current count), counting continues and wraps naturally. Terminal detection is equality only.

Test Plan:
- Reset, hold: WIDTH=8, DIV=4, clr held 3 cycles with key_start=1 held throughout -> after release: state=00, cnt_clr low, no start fires until key_start goes 0 then 1.
- Run to limit, no reload: limit=5, reload=0, pulse start -> tick every 4th cycle; cnt_en on ticks while cnt_q=0..4; at the 6th tick (cnt_q=5) state=11, done=1; counter holds 5.
- Run to limit, reload: same with reload=1 -> sequence 0..5, then cnt_clr on the tick where cnt_q=5, then 0,1,…; done stays 0.
- Pause/resume: stop 2 cycles after a tick -> state=10, prescaler frozen at 2; start -> first tick exactly 1 cycle after the RUN re-entry cycle; count continues without loss.
- Simultaneous keys: stop and start edges in the same cycle while RUN -> PAUSE. Clear+stop -> IDLE with cnt_clr=1. Clear in DONE -> IDLE. Start in DONE -> RUN with cnt_clr, counter=0.
- Edge cases: DIV=1, limit=0, reload=0 -> DONE on the first RUN cycle. clr asserted mid-RUN at cnt_q=3 -> next cycle IDLE, counter cleared.
